// File: rtl/digit_entry_pkg.sv
// digit_entry_pkg
//   Shared game package. Holds the default digit count and result width,
//   the entry FSM state type and the BCD digit type.
package digit_entry_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int VALUE_W    = 14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CONVERT,
    ST_HOLD
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/digit_entry_bcd_to_bin_seq.sv
// bcd_to_bin_seq
//   Iterative BCD to binary converter, one digit per clock, MSD first:
//   acc = acc*10 + digit, with *10 done as (acc<<3)+(acc<<1).
//   Ports:
//     clk, rst  - system clock, async active-high reset
//     start     - one-cycle pulse; captures digits and begins conversion
//     abort     - drops any conversion in flight
//     digits    - right-aligned BCD buffer, leading positions zero
//     result    - value after the current iteration (valid while done=1)
//     done      - high during the cycle whose edge completes the last digit
module bcd_to_bin_seq #(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [4*NUM_DIGITS-1:0] digits,
  output logic [VALUE_W-1:0]      result,
  output logic                    done
);
  import digit_entry_pkg::bcd_t;

  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NUM_DIGITS - 1);

  logic                    running;
  logic [CNT_W-1:0]        iter;
  logic [VALUE_W-1:0]      acc;
  logic [4*NUM_DIGITS-1:0] shift;
  bcd_t                    msd;
  logic [VALUE_W-1:0]      acc_next;

  assign msd      = shift[4*NUM_DIGITS-1 -: 4];
  assign acc_next = (acc << 3) + (acc << 1) + VALUE_W'(msd);

  // Result is exposed combinationally so the caller can register it on the
  // same edge that retires the final digit.
  assign done   = running && (iter == '0);
  assign result = acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      iter    <= '0;
      acc     <= '0;
      shift   <= '0;
    end else if (abort) begin
      running <= 1'b0;
      acc     <= '0;
    end else if (start) begin
      running <= 1'b1;
      iter    <= LAST_ITER;
      acc     <= '0;
      shift   <= digits;
    end else if (running) begin
      acc   <= acc_next;
      shift <= shift << 4;
      iter  <= iter - 1'b1;
      if (iter == '0) running <= 1'b0;
    end
  end

endmodule

// File: rtl/digit_entry.sv
// digit_entry
//   Keypad digit entry for the guessing game: buffers up to NUM_DIGITS BCD
//   digits with backspace, converts them to binary on submit and holds the
//   result for the comparator until ack.
//   Ports:
//     clk, rst      - system clock, async active-high reset
//     enable        - entry phase armed by the game controller
//     digit_in      - BCD digit, taken on digit_strobe
//     digit_strobe  - one-cycle pulse accepting digit_in
//     backspace     - one-cycle pulse removing the last digit
//     submit        - one-cycle pulse requesting conversion
//     ack           - comparator has consumed user_int
//     user_int      - binary value of the entered digits
//     user_valid    - user_int final and stable
//     digit_count   - digits currently buffered
//     disp_bcd      - right-aligned buffered digits, unused positions 0
//     entry_err     - one-cycle pulse when an input is rejected
//     busy          - conversion in progress
//
//   state      | meaning
//   -----------+-------------------------------------------------
//   ST_IDLE    | entry not armed, buffer empty
//   ST_ENTRY   | collecting digits, backspace and submit
//   ST_CONVERT | sequential BCD to binary conversion running
//   ST_HOLD    | user_int valid, waiting for ack
module digit_entry #(
  parameter int NUM_DIGITS = digit_entry_pkg::NUM_DIGITS,
  parameter int VALUE_W    = digit_entry_pkg::VALUE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [3:0]              digit_in,
  input  logic                    digit_strobe,
  input  logic                    backspace,
  input  logic                    submit,
  input  logic                    ack,
  output logic [VALUE_W-1:0]      user_int,
  output logic                    user_valid,
  output logic [2:0]              digit_count,
  output logic [4*NUM_DIGITS-1:0] disp_bcd,
  output logic                    entry_err,
  output logic                    busy
);
  import digit_entry_pkg::state_t;
  import digit_entry_pkg::ST_IDLE;
  import digit_entry_pkg::ST_ENTRY;
  import digit_entry_pkg::ST_CONVERT;
  import digit_entry_pkg::ST_HOLD;
  import digit_entry_pkg::BCD_MAX;

  localparam int         DISP_W  = 4 * NUM_DIGITS;
  localparam logic [2:0] MAX_CNT = 3'(NUM_DIGITS);

  state_t              state, state_next;
  logic [DISP_W-1:0]   buffer, buffer_shl;
  logic [2:0]          count;
  logic                push, pop, clear, err_set, conv_start, load;
  logic                conv_done;
  logic [VALUE_W-1:0]  conv_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Pulse priority inside ENTRY is submit > backspace > digit_strobe; the
  // losing pulses fall through the if/else chain and are simply dropped.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    pop        = 1'b0;
    clear      = 1'b0;
    err_set    = 1'b0;
    conv_start = 1'b0;
    load       = 1'b0;
    if (!enable) begin
      state_next = ST_IDLE;
      clear      = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next = ST_ENTRY;
          clear      = 1'b1;
        end
        ST_ENTRY: begin
          if (submit) begin
            if (count != 3'd0) begin
              state_next = ST_CONVERT;
              conv_start = 1'b1;
            end else begin
              err_set = 1'b1;
            end
          end else if (backspace) begin
            pop = (count != 3'd0);
          end else if (digit_strobe) begin
            if ((digit_in <= BCD_MAX) && (count < MAX_CNT)) push = 1'b1;
            else                                           err_set = 1'b1;
          end
        end
        ST_CONVERT: begin
          if (conv_done) begin
            state_next = ST_HOLD;
            load       = 1'b1;
          end
        end
        ST_HOLD: begin
          if (ack) begin
            state_next = ST_ENTRY;
            clear      = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    buffer_shl      = buffer << 4;
    buffer_shl[3:0] = digit_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer     <= '0;
      count      <= '0;
      entry_err  <= 1'b0;
      user_int   <= '0;
      user_valid <= 1'b0;
    end else begin
      if (clear) begin
        buffer <= '0;
        count  <= '0;
      end else if (push) begin
        buffer <= buffer_shl;
        count  <= count + 3'd1;
      end else if (pop) begin
        buffer <= buffer >> 4;
        count  <= count - 3'd1;
      end
      entry_err  <= err_set;
      if (load) user_int <= conv_result;
      // Valid exactly while resident in HOLD; any exit drops it.
      user_valid <= (state_next == ST_HOLD);
    end
  end

  bcd_to_bin_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .VALUE_W    (VALUE_W)
  ) u_conv (
    .clk    (clk),
    .rst    (rst),
    .start  (conv_start),
    .abort  (!enable),
    .digits (buffer),
    .result (conv_result),
    .done   (conv_done)
  );

  assign digit_count = count;
  assign disp_bcd    = buffer;
  assign busy        = (state == ST_CONVERT);

endmodule

// File: tb/tb_digit_entry.sv
module tb_digit_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  digit_in;
  logic        digit_strobe, backspace, submit, ack;
  logic [13:0] user_int;
  logic        user_valid;
  logic [2:0]  digit_count;
  logic [15:0] disp_bcd;
  logic        entry_err, busy;

  int n_pass = 0;
  int n_tot  = 0;

  digit_entry dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .digit_in     (digit_in),
    .digit_strobe (digit_strobe),
    .backspace    (backspace),
    .submit       (submit),
    .ack          (ack),
    .user_int     (user_int),
    .user_valid   (user_valid),
    .digit_count  (digit_count),
    .disp_bcd     (disp_bcd),
    .entry_err    (entry_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  d;
    logic        stb, bs, sub, ak;
    logic [2:0]  cnt;
    logic [15:0] disp;
    logic        err, valid, bsy;
    logic [13:0] ui;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic en, input logic [3:0] d, input logic stb, input logic bs,
                   input logic sub, input logic ak, input logic [2:0] cnt, input logic [15:0] disp,
                   input logic err, input logic valid, input logic bsy, input logic [13:0] ui);
    vec_t r;
    r.en = en; r.d = d; r.stb = stb; r.bs = bs; r.sub = sub; r.ak = ak;
    r.cnt = cnt; r.disp = disp; r.err = err; r.valid = valid; r.bsy = bsy; r.ui = ui;
    vecs.push_back(r);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] actual=%0h required=%0h", nm, idx, act, exp);
  endtask

  task automatic chk_all_zero(input string nm, input int idx);
    chk({nm, "_user_int"}, idx, 32'(user_int), 32'd0);
    chk({nm, "_valid"},    idx, 32'(user_valid), 32'd0);
    chk({nm, "_count"},    idx, 32'(digit_count), 32'd0);
    chk({nm, "_disp"},     idx, 32'(disp_bcd), 32'd0);
    chk({nm, "_err"},      idx, 32'(entry_err), 32'd0);
    chk({nm, "_busy"},     idx, 32'(busy), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    digit_strobe = 1'b0; backspace = 1'b0; submit = 1'b0; ack = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    digit_in = d; digit_strobe = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; digit_in = 4'd0;
    digit_strobe = 1'b0; backspace = 1'b0; submit = 1'b0; ack = 1'b0;

    // en d stb bs sub ak | cnt disp err valid busy user_int
    // 4,0,9,5 -> 4095, valid on 4th edge after submit, held, ack back to ENTRY
    v(1,0,0,0,0,0, 0,16'h0000,0,0,0,14'd0);
    v(1,4,1,0,0,0, 1,16'h0004,0,0,0,14'd0);
    v(1,0,1,0,0,0, 2,16'h0040,0,0,0,14'd0);
    v(1,9,1,0,0,0, 3,16'h0409,0,0,0,14'd0);
    v(1,5,1,0,0,0, 4,16'h4095,0,0,0,14'd0);
    v(1,0,0,0,1,0, 4,16'h4095,0,0,1,14'd0);
    v(1,0,0,0,0,0, 4,16'h4095,0,0,1,14'd0);
    v(1,0,0,0,0,0, 4,16'h4095,0,0,1,14'd0);
    v(1,0,0,0,0,0, 4,16'h4095,0,0,1,14'd0);
    v(1,0,0,0,0,0, 4,16'h4095,0,1,0,14'h0FFF);
    v(1,1,1,1,1,0, 4,16'h4095,0,1,0,14'h0FFF);
    v(1,0,0,0,0,0, 4,16'h4095,0,1,0,14'h0FFF);
    v(1,0,0,0,0,1, 0,16'h0000,0,0,0,14'h0FFF);
    // 7, backspace, 3; backspace beats strobe; ack during CONVERT ignored
    v(1,7,1,0,0,0, 1,16'h0007,0,0,0,14'h0FFF);
    v(1,0,0,1,0,0, 0,16'h0000,0,0,0,14'h0FFF);
    v(1,3,1,0,0,0, 1,16'h0003,0,0,0,14'h0FFF);
    v(1,5,1,1,0,0, 0,16'h0000,0,0,0,14'h0FFF);
    v(1,0,0,1,0,0, 0,16'h0000,0,0,0,14'h0FFF);
    v(1,3,1,0,0,0, 1,16'h0003,0,0,0,14'h0FFF);
    v(1,0,0,0,1,0, 1,16'h0003,0,0,1,14'h0FFF);
    v(1,0,0,0,0,1, 1,16'h0003,0,0,1,14'h0FFF);
    v(1,0,0,0,0,0, 1,16'h0003,0,0,1,14'h0FFF);
    v(1,0,0,0,0,0, 1,16'h0003,0,0,1,14'h0FFF);
    v(1,0,0,0,0,0, 1,16'h0003,0,1,0,14'd3);
    v(1,0,0,0,0,1, 0,16'h0000,0,0,0,14'd3);
    // 1..5 then 0xA: two rejects, result 1234
    v(1,1,1,0,0,0, 1,16'h0001,0,0,0,14'd3);
    v(1,2,1,0,0,0, 2,16'h0012,0,0,0,14'd3);
    v(1,3,1,0,0,0, 3,16'h0123,0,0,0,14'd3);
    v(1,4,1,0,0,0, 4,16'h1234,0,0,0,14'd3);
    v(1,5,1,0,0,0, 4,16'h1234,1,0,0,14'd3);
    v(1,0,0,0,0,0, 4,16'h1234,0,0,0,14'd3);
    v(1,4'hA,1,0,0,0, 4,16'h1234,1,0,0,14'd3);
    v(1,0,0,0,1,0, 4,16'h1234,0,0,1,14'd3);
    v(1,0,0,0,0,0, 4,16'h1234,0,0,1,14'd3);
    v(1,0,0,0,0,0, 4,16'h1234,0,0,1,14'd3);
    v(1,0,0,0,0,0, 4,16'h1234,0,0,1,14'd3);
    v(1,0,0,0,0,0, 4,16'h1234,0,1,0,14'd1234);
    v(1,0,0,0,0,1, 0,16'h0000,0,0,0,14'd1234);
    // submit on empty buffer; submit+strobe with 2 digits drops the digit
    v(1,0,0,0,1,0, 0,16'h0000,1,0,0,14'd1234);
    v(1,2,1,0,0,0, 1,16'h0002,0,0,0,14'd1234);
    v(1,6,1,0,0,0, 2,16'h0026,0,0,0,14'd1234);
    v(1,8,1,0,1,0, 2,16'h0026,0,0,1,14'd1234);
    v(1,0,0,0,0,0, 2,16'h0026,0,0,1,14'd1234);
    v(1,0,0,0,0,0, 2,16'h0026,0,0,1,14'd1234);
    v(1,0,0,0,0,0, 2,16'h0026,0,0,1,14'd1234);
    v(1,0,0,0,0,0, 2,16'h0026,0,1,0,14'd26);
    v(1,0,0,0,0,1, 0,16'h0000,0,0,0,14'd26);
    // 9999, then again with enable dropped during CONVERT
    v(1,9,1,0,0,0, 1,16'h0009,0,0,0,14'd26);
    v(1,9,1,0,0,0, 2,16'h0099,0,0,0,14'd26);
    v(1,9,1,0,0,0, 3,16'h0999,0,0,0,14'd26);
    v(1,9,1,0,0,0, 4,16'h9999,0,0,0,14'd26);
    v(1,0,0,0,1,0, 4,16'h9999,0,0,1,14'd26);
    v(1,0,0,0,0,0, 4,16'h9999,0,0,1,14'd26);
    v(1,0,0,0,0,0, 4,16'h9999,0,0,1,14'd26);
    v(1,0,0,0,0,0, 4,16'h9999,0,0,1,14'd26);
    v(1,0,0,0,0,0, 4,16'h9999,0,1,0,14'h270F);
    v(1,0,0,0,0,1, 0,16'h0000,0,0,0,14'h270F);
    v(1,9,1,0,0,0, 1,16'h0009,0,0,0,14'h270F);
    v(1,9,1,0,0,0, 2,16'h0099,0,0,0,14'h270F);
    v(1,9,1,0,0,0, 3,16'h0999,0,0,0,14'h270F);
    v(1,9,1,0,0,0, 4,16'h9999,0,0,0,14'h270F);
    v(1,0,0,0,1,0, 4,16'h9999,0,0,1,14'h270F);
    v(0,0,0,0,0,0, 0,16'h0000,0,0,0,14'h270F);
    v(0,0,0,0,0,0, 0,16'h0000,0,0,0,14'h270F);
    v(0,0,0,0,0,0, 0,16'h0000,0,0,0,14'h270F);
    v(0,0,0,0,0,0, 0,16'h0000,0,0,0,14'h270F);
    v(0,0,0,0,0,1, 0,16'h0000,0,0,0,14'h270F);
    v(0,0,0,0,0,0, 0,16'h0000,0,0,0,14'h270F);
    v(1,5,1,0,0,0, 0,16'h0000,0,0,0,14'h270F);
    v(1,5,1,0,0,0, 1,16'h0005,0,0,0,14'h270F);

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset", 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      enable = vecs[i].en; digit_in = vecs[i].d;
      digit_strobe = vecs[i].stb; backspace = vecs[i].bs;
      submit = vecs[i].sub; ack = vecs[i].ak;
      step();
      chk("count",    i, 32'(digit_count), 32'(vecs[i].cnt));
      chk("disp",     i, 32'(disp_bcd),    32'(vecs[i].disp));
      chk("err",      i, 32'(entry_err),   32'(vecs[i].err));
      chk("valid",    i, 32'(user_valid),  32'(vecs[i].valid));
      chk("busy",     i, 32'(busy),        32'(vecs[i].bsy));
      chk("user_int", i, 32'(user_int),    32'(vecs[i].ui));
    end

    // Async reset mid-ENTRY with 3 digits buffered (5 already in place)
    key(4'd1);
    key(4'd2);
    chk("pre_rst_count", 0, 32'(digit_count), 32'd3);
    chk("pre_rst_disp",  0, 32'(disp_bcd), 32'h0512);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst_entry", 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_valid", i, 32'(user_valid), 32'd0);
      chk("post_rst_count", i, 32'(digit_count), 32'd0);
    end

    // Async reset mid-CONVERT: no result may appear afterwards
    key(4'd8);
    key(4'd1);
    submit = 1'b1;
    step();
    step();
    chk("pre_rst_busy", 1, 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst_conv", 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_conv_rst_valid", i, 32'(user_valid), 32'd0);
      chk("post_conv_rst_busy",  i, 32'(busy), 32'd0);
      chk("post_conv_rst_int",   i, 32'(user_int), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/digit_entry.md
DIGIT_ENTRY -- requirements
Module: digit_entry

Interface
REQ-001 The block SHALL take parameter NUM_DIGITS, default 4, as the number of decimal digits the player may enter.
REQ-002 The block SHALL take parameter VALUE_W, default 14, as the width of the binary result; it must hold 10^NUM_DIGITS-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit: entry phase armed by the game controller.
REQ-006 The block SHALL have port digit_in, input, 4 bits: BCD digit from the keypad or switches.
REQ-007 The block SHALL have port digit_strobe, input, 1 bit: one-cycle pulse that accepts digit_in (already synchronised and edge-detected upstream).
REQ-008 The block SHALL have port backspace, input, 1 bit: one-cycle pulse that removes the last entered digit.
REQ-009 The block SHALL have port submit, input, 1 bit: one-cycle pulse that requests conversion.
REQ-010 The block SHALL have port ack, input, 1 bit: the comparator stage has consumed user_int.
REQ-011 The block SHALL have port user_int, output, VALUE_W bits: the binary value of the entered digits, feeding the comparator.
REQ-012 The block SHALL have port user_valid, output, 1 bit: user_int is final and stable.
REQ-013 The block SHALL have port digit_count, output, 3 bits: number of digits currently buffered.
REQ-014 The block SHALL have port disp_bcd, output, 4*NUM_DIGITS bits: right-aligned BCD digits for the seven-segment display, with unused positions at 0.
REQ-015 The block SHALL have port entry_err, output, 1 bit: one-cycle pulse when an input is rejected.
REQ-016 The block SHALL have port busy, output, 1 bit: high while in the CONVERT state.

Function
REQ-017 The state machine SHALL have the states IDLE, ENTRY, CONVERT and HOLD, and SHALL leave reset in IDLE.
REQ-018 IDLE: when enable=1 the block SHALL go to ENTRY with the digit buffer and digit_count cleared.
REQ-019 Deasserting enable in any state SHALL go to IDLE on the next edge, clearing the buffer and dropping user_valid; user_int keeps its last value.
REQ-020 ENTRY, digit_strobe with digit_in<=9 and count<NUM_DIGITS: the buffer SHALL shift left one digit, append digit_in in the LSD position and increment digit_count.
REQ-021 ENTRY, digit_strobe with digit_in>9 or count==NUM_DIGITS: the buffer SHALL be unchanged and entry_err SHALL pulse for one cycle.
REQ-022 ENTRY, backspace with count>0: the buffer SHALL shift right one digit and digit_count SHALL decrement; backspace with count==0 SHALL be ignored without an error.
REQ-023 ENTRY, submit with count>=1: the block SHALL go to CONVERT; submit with count==0 SHALL pulse entry_err and stay in ENTRY.
REQ-024 Simultaneous pulses SHALL be prioritised submit > backspace > digit_strobe; a lower-priority pulse in the same cycle SHALL be discarded silently.
REQ-025 CONVERT SHALL run exactly NUM_DIGITS iterations, MSD first, over the right-aligned buffer with leading zeros: acc = acc*10 + digit.
REQ-026 The multiply by 10 SHALL be computed as (acc<<3)+(acc<<1) in VALUE_W bits; no overflow is possible by construction.
REQ-027 Strobe, backspace and submit inputs SHALL be ignored in CONVERT and HOLD.
REQ-028 Latency: user_int SHALL be loaded and user_valid set at the NUM_DIGITS-th edge after the edge that sampled submit, and the block SHALL then be in HOLD.
REQ-029 HOLD: user_valid=1 and user_int SHALL be held stable until ack.
REQ-030 On ack in HOLD, user_valid SHALL clear on the next edge and the block SHALL go to ENTRY with the buffer cleared if enable=1, otherwise to IDLE.
REQ-031 An ack received outside HOLD SHALL be ignored.
REQ-032 disp_bcd and digit_count SHALL track the buffer combinationally from registers, with no added latency.

Reset
REQ-033 rst SHALL immediately force state=IDLE, user_int=0, user_valid=0, digit_count=0, disp_bcd=0, entry_err=0, busy=0 and the accumulator to 0.
REQ-034 Reset asserted mid-ENTRY or mid-CONVERT SHALL abandon the operation with no user_valid pulse after release.

Structure
REQ-035 The shared game package SHALL hold NUM_DIGITS, VALUE_W, the state enum type and the BCD digit type.
REQ-036 The iterative converter SHALL be a sub-module bcd_to_bin_seq with start/done handshake; the FSM, buffer and error logic SHALL stay in digit_entry.

Verification
REQ-037 The bench SHALL drive enable=1, digits 4,0,9,5, then submit, and check user_int=4095 (14'h0FFF) with user_valid 4 edges after submit, held until ack, then back in ENTRY.
REQ-038 The bench SHALL drive digit 7, backspace, digit 3, then submit, and check user_int=3 with digit_count going 1,0,1.
REQ-039 The bench SHALL drive digits 1,2,3,4,5, then digit 0xA, then submit, and check one entry_err pulse for each of the last two digits and user_int=1234.
REQ-040 The bench SHALL drive submit with count 0, check entry_err with the block still in ENTRY; then drive submit and digit_strobe in the same cycle with count 2, and check the digit is dropped and conversion starts.
REQ-041 The bench SHALL drive digits 9,9,9,9 and submit, and check user_int=9999 (14'h270F); then repeat with enable dropped during CONVERT, and check for IDLE with no user_valid.
REQ-042 The bench SHALL assert rst asynchronously mid-ENTRY with 3 digits buffered, and check all outputs are 0 before the next clock edge.
